// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI read path: read-buffer sizing, transfer
// length limit and the read-buffer FSM state encoding.
package qspi_pkg;

    localparam int RD_BUF_DEPTH = 16;
    localparam int MAX_BEATS    = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } rd_buf_state_t;

endpackage

// File: rtl/qspi_rd_buffer_if.sv
// Bus bundle between the QSPI datapath / AHB side (master) and the read buffer (slave).
interface qspi_rd_buffer_if #(
    parameter int DATA_W = 32
);

    logic              start_in;
    logic [4:0]        beats_in;
    logic              push_in;
    logic [DATA_W-1:0] push_data_in;
    logic              pop_in;
    logic              flush_in;
    logic [DATA_W-1:0] rd_data_out;
    logic              rd_valid_out;
    logic              full_out;
    logic [4:0]        count_out;
    logic              burst_comp_out;
    logic              ovf_err_out;

    modport master (
        output start_in, beats_in, push_in, push_data_in, pop_in, flush_in,
        input  rd_data_out, rd_valid_out, full_out, count_out, burst_comp_out, ovf_err_out
    );

    modport slave (
        input  start_in, beats_in, push_in, push_data_in, pop_in, flush_in,
        output rd_data_out, rd_valid_out, full_out, count_out, burst_comp_out, ovf_err_out
    );

endinterface

// File: rtl/qspi_sync_fifo.sv
// Single-clock word FIFO with a combinational head read; occupancy is tracked
// by an explicit counter so full/empty never depend on pointer equality.
module qspi_sync_fifo #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 16,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              h_clk,
    input  logic              h_rstn,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              wr_ok;
    logic              rd_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full && !clr;
    assign rd_ok   = rd_en && !empty && !clr;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge h_clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge h_clk) begin
        if (!h_rstn || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/qspi_rd_buffer.sv
// QSPI read buffer: burst-tracking FSM, beat counters and overflow flag around a word FIFO.
// Define QSPI_RD_BUF_BYTE_SWAP_EN to store incoming words byte-reversed.
module qspi_rd_buffer
    import qspi_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = RD_BUF_DEPTH
) (
    input  logic               h_clk,
    input  logic               h_rstn,
    qspi_rd_buffer_if.slave    bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    rd_buf_state_t     state;
    rd_buf_state_t     state_nxt;
    logic [4:0]        push_rem;
    logic [4:0]        pop_rem;
    logic              ovf_err;
    logic              burst_comp;
    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic              start_ok;
    logic              push_acc;
    logic              push_err;
    logic              pop_acc;
    logic              last_pop;

`ifdef QSPI_RD_BUF_BYTE_SWAP_EN
    always_comb begin
        wr_word = bus.push_data_in;
        for (int b = 0; b < DATA_W / 8; b++) begin
            wr_word[8*b +: 8] = bus.push_data_in[DATA_W-8-8*b +: 8];
        end
    end
`else
    assign wr_word = bus.push_data_in;
`endif

    always_ff @(posedge h_clk) begin
        if (!h_rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Flush outranks every other request; a push that is refused for any other reason is an overflow.
    always_comb begin
        start_ok  = !bus.flush_in && bus.start_in && (state == ST_IDLE) &&
                    (bus.beats_in != 5'd0) && (bus.beats_in <= 5'(MAX_BEATS));
        push_acc  = !bus.flush_in && bus.push_in && (state == ST_ACTIVE) && !fifo_full;
        push_err  = !bus.flush_in && bus.push_in && ((state != ST_ACTIVE) || fifo_full);
        pop_acc   = !bus.flush_in && bus.pop_in && !fifo_empty;
        last_pop  = pop_acc && (state != ST_IDLE) && (pop_rem == 5'd1);
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start_ok) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (push_acc && (push_rem == 5'd1)) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (last_pop) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        if (bus.flush_in) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge h_clk) begin
        if (!h_rstn) begin
            push_rem   <= '0;
            pop_rem    <= '0;
            ovf_err    <= 1'b0;
            burst_comp <= 1'b0;
        end else begin
            burst_comp <= last_pop;
            if (bus.flush_in) begin
                push_rem <= '0;
                pop_rem  <= '0;
            end else if (start_ok) begin
                push_rem <= bus.beats_in;
                pop_rem  <= bus.beats_in;
            end else begin
                if (push_acc) begin
                    push_rem <= push_rem - 1'b1;
                end
                if (pop_acc && (pop_rem != 5'd0)) begin
                    pop_rem <= pop_rem - 1'b1;
                end
            end
            if (push_err) begin
                ovf_err <= 1'b1;
            end else if (start_ok) begin
                ovf_err <= 1'b0;
            end
        end
    end

    qspi_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .h_clk   (h_clk),
        .h_rstn  (h_rstn),
        .clr     (bus.flush_in),
        .wr_en   (push_acc),
        .wr_data (wr_word),
        .rd_en   (pop_acc),
        .rd_data (head),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign bus.rd_data_out    = head;
    assign bus.rd_valid_out   = !fifo_empty;
    assign bus.full_out       = fifo_full;
    assign bus.count_out      = 5'(fifo_count);
    assign bus.burst_comp_out = burst_comp;
    assign bus.ovf_err_out    = ovf_err;

endmodule
